// File: rtl/latch_bank_ctrl_pkg.sv
// Shared state type and sizing helpers for the latch bank write controller.
package latch_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ENABLE,
      HOLD,
      CLEAR
   } lat_state_e;

   function automatic int lat_aw(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int phase_cw(input int s, input int e, input int h);
      int m;
      m = s;
      if (e > m) m = e;
      if (h > m) m = h;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/latch_bank_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after i_ptr.
module rr_arbiter
   import latch_ctrl_pkg::*;
#(
   parameter int  NREQ = 4,
   localparam int PW   = lat_aw(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [PW-1:0]   o_idx,
   output logic            o_any
);

   logic [2*NREQ-1:0] w_dbl;
   logic [NREQ-1:0]   w_rot;
   logic [PW:0]       w_sum;

   always_comb begin
      w_dbl = {i_req, i_req} >> i_ptr;
      w_rot = w_dbl[NREQ-1:0];
      w_sum = '0;
      o_any = 1'b0;
      // descending scan leaves the lowest rotated hit in w_sum
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(k);
            o_any = 1'b1;
         end
      end
      if (w_sum >= (PW+1)'(NREQ))
         w_sum = w_sum - (PW+1)'(NREQ);
      o_idx = w_sum[PW-1:0];
      o_gnt = '0;
      o_gnt[o_idx] = o_any;
   end

endmodule

// File: rtl/latch_bank_ctrl.sv
// Write sequencer/arbiter for a bank of level-sensitive latches.
// Define LATCH_SHADOW_EN to add a readable shadow copy of the bank.
module latch_bank_ctrl
   import latch_ctrl_pkg::*;
#(
   parameter int  NREQ      = 4,
   parameter int  NLAT      = 8,
   parameter int  DW        = 8,
   parameter int  SETUP_CYC = 1,
   parameter int  EN_CYC    = 1,
   parameter int  HOLD_CYC  = 1,
   localparam int AW        = lat_aw(NLAT)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic               clr,
   output logic [NREQ-1:0]    ack,
   output logic               err,
   output logic               clr_done,
   output logic               busy,
   output logic [DW-1:0]      lat_d,
   output logic [NLAT-1:0]    lat_en,
   output logic               lat_rst_n
`ifdef LATCH_SHADOW_EN
   ,
   input  logic [AW-1:0]      rd_addr,
   output logic [DW-1:0]      rd_data
`endif
);

   localparam int PW = lat_aw(NREQ);
   localparam int CW = phase_cw(SETUP_CYC, EN_CYC, HOLD_CYC);

   lat_state_e      r_state, w_nstate;
   logic [CW-1:0]   r_cnt, w_ncnt;
   logic [PW-1:0]   r_ptr, r_win, w_idx, w_pnext;
   logic [NREQ-1:0] r_win_oh, w_gnt;
   logic [AW-1:0]   r_addr, w_addr;
   logic [DW-1:0]   r_data, w_data;
   logic [NLAT-1:0] w_dec;
   logic            w_any, w_cap, w_last, w_oob;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign w_last  = (r_cnt == '0);
   assign w_oob   = ({1'b0, r_addr} >= (AW+1)'(NLAT));
   assign w_pnext = (r_win == PW'(NREQ - 1)) ? '0 : r_win + PW'(1);

   always_comb begin
      w_addr = '0;
      w_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_addr = req_addr[i*AW +: AW];
            w_data = req_data[i*DW +: DW];
         end
      end
   end

   always_comb begin
      w_dec = '0;
      for (int i = 0; i < NLAT; i++)
         w_dec[i] = (r_addr == AW'(i));
   end

   always_comb begin
      w_nstate = r_state;
      w_ncnt   = r_cnt;
      w_cap    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (clr) begin
               w_nstate = CLEAR;
               w_ncnt   = CW'(1);
            end else if (w_any) begin
               w_nstate = SETUP;
               w_ncnt   = CW'(SETUP_CYC - 1);
               w_cap    = 1'b1;
            end
         end
         SETUP: begin
            if (w_last) begin
               w_nstate = ENABLE;
               w_ncnt   = CW'(EN_CYC - 1);
            end else begin
               w_ncnt = r_cnt - CW'(1);
            end
         end
         ENABLE: begin
            if (w_last) begin
               w_nstate = HOLD;
               w_ncnt   = CW'(HOLD_CYC - 1);
            end else begin
               w_ncnt = r_cnt - CW'(1);
            end
         end
         HOLD, CLEAR: begin
            if (w_last) w_nstate = IDLE;
            else        w_ncnt   = r_cnt - CW'(1);
         end
         default: w_nstate = IDLE;
      endcase
   end

   // outputs are registered decodes of the current phase
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_ptr     <= '0;
         r_win     <= '0;
         r_win_oh  <= '0;
         r_addr    <= '0;
         r_data    <= '0;
         ack       <= '0;
         err       <= 1'b0;
         clr_done  <= 1'b0;
         busy      <= 1'b0;
         lat_d     <= '0;
         lat_en    <= '0;
         lat_rst_n <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_cnt   <= w_ncnt;
         if (w_cap) begin
            r_win    <= w_idx;
            r_win_oh <= w_gnt;
            r_addr   <= w_addr;
            r_data   <= w_data;
         end
         if (r_state == HOLD && w_last)
            r_ptr <= w_pnext;
         if (r_state == SETUP)
            lat_d <= r_data;
         busy      <= (r_state != IDLE);
         lat_en    <= (r_state == ENABLE) ? w_dec : '0;
         ack       <= (r_state == HOLD && w_last) ? r_win_oh : '0;
         err       <= (r_state == HOLD) && w_last && w_oob;
         clr_done  <= (r_state == CLEAR) && w_last;
         lat_rst_n <= !((r_state == CLEAR) && !w_last);
      end
   end

`ifdef LATCH_SHADOW_EN
   logic [DW-1:0] r_shadow [NLAT];

   always_ff @(posedge clk) begin
      if (!reset || r_state == CLEAR) begin
         for (int i = 0; i < NLAT; i++)
            r_shadow[i] <= '0;
      end else if (r_state == ENABLE && w_last && !w_oob) begin
         r_shadow[r_addr] <= r_data;
      end
      if (!reset)
         rd_data <= '0;
      else if ({1'b0, rd_addr} < (AW+1)'(NLAT))
         rd_data <= r_shadow[rd_addr];
      else
         rd_data <= '0;
   end
`endif

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Scoreboard bench for latch_bank_ctrl: stimulus queues expected events, monitors pop them.
module tb_latch_bank_ctrl;

   localparam int NREQ = 4;
   localparam int NLAT = 8;
   localparam int DW   = 8;
   localparam int AW   = 3;

   typedef struct {
      int         kind;
      logic [3:0] ack;
      logic       err;
      logic [7:0] en;
      logic [7:0] d;
      int         t0;
      int         lat;
      int         gap;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]    req = '0;
   logic [NREQ*AW-1:0] req_addr = '0;
   logic [NREQ*DW-1:0] req_data = '0;
   logic               clr = 1'b0;
   logic [NREQ-1:0]    ack;
   logic               err, clr_done, busy, lat_rst_n;
   logic [DW-1:0]      lat_d;
   logic [NLAT-1:0]    lat_en;

   logic [NREQ-1:0]    req6 = '0;
   logic [NREQ*AW-1:0] addr6 = '0;
   logic [NREQ*DW-1:0] data6 = '0;
   logic [NREQ-1:0]    ack6;
   logic               err6, clr_done6, busy6, lat_rst_n6;
   logic [DW-1:0]      lat_d6;
   logic [5:0]         lat_en6;

`ifdef LATCH_SHADOW_EN
   logic [AW-1:0] rd_addr = '0, rd_addr6 = '0;
   logic [DW-1:0] rd_data, rd_data6;
`endif

   latch_bank_ctrl u_dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .clr       (clr),
      .ack       (ack),
      .err       (err),
      .clr_done  (clr_done),
      .busy      (busy),
      .lat_d     (lat_d),
      .lat_en    (lat_en),
      .lat_rst_n (lat_rst_n)
`ifdef LATCH_SHADOW_EN
      ,
      .rd_addr   (rd_addr),
      .rd_data   (rd_data)
`endif
   );

   latch_bank_ctrl #(.NLAT(6)) u_dut6 (
      .clk       (clk),
      .reset     (reset),
      .req       (req6),
      .req_addr  (addr6),
      .req_data  (data6),
      .clr       (1'b0),
      .ack       (ack6),
      .err       (err6),
      .clr_done  (clr_done6),
      .busy      (busy6),
      .lat_d     (lat_d6),
      .lat_en    (lat_en6),
      .lat_rst_n (lat_rst_n6)
`ifdef LATCH_SHADOW_EN
      ,
      .rd_addr   (rd_addr6),
      .rd_data   (rd_data6)
`endif
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc_p = 0;
   exp_t q[$];
   exp_t q6[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(int kind, logic [3:0] a, logic e, logic [7:0] en,
                               logic [7:0] d, int t0, int lat, int gap);
      exp_t x;
      x.kind = kind; x.ack = a; x.err = e; x.en = en;
      x.d = d; x.t0 = t0; x.lat = lat; x.gap = gap;
      return x;
   endfunction

   always @(posedge clk) cyc_p++;

   int         last_ev = 0, en_cnt = 0, rlo_cnt = 0;
   logic [7:0] en_or = '0, d_en = '0;
   exp_t       e;

   always @(negedge clk) begin
      if (!reset) begin
         en_or = '0; en_cnt = 0; rlo_cnt = 0;
      end else begin
         if (lat_en != '0) begin
            en_or |= lat_en; en_cnt++; d_en = lat_d;
         end
         if (!lat_rst_n) rlo_cnt++;
         if (q.size() > 0 && q[0].kind == 0 && q[0].lat >= 0 && cyc_p == q[0].t0 + 1)
            chk("lat_d_after_capture", lat_d, q[0].d);
         if (ack != '0 || clr_done) begin
            if (q.size() == 0) begin
               chk("unexpected_event", {ack, clr_done}, 0);
            end else begin
               e = q.pop_front();
               if (e.kind == 0) begin
                  chk("ack", ack, e.ack);
                  chk("err", err, e.err);
                  chk("lat_en_mask", en_or, e.en);
                  chk("lat_en_cycles", en_cnt, (e.en != 0) ? 1 : 0);
                  if (e.en != 0) chk("lat_d_at_en", d_en, e.d);
               end else begin
                  chk("clr_done_ack", ack, 0);
                  chk("clr_rst_lo_cycles", rlo_cnt, 1);
                  chk("clr_lat_en", en_cnt, 0);
               end
               if (e.lat >= 0) chk("latency", cyc_p - e.t0, e.lat);
               if (e.gap > 0)  chk("gap", cyc_p - last_ev, e.gap);
            end
            last_ev = cyc_p; en_or = '0; en_cnt = 0; rlo_cnt = 0;
         end
      end
   end

   logic [5:0] en6_or = '0;
   exp_t       e6;

   always @(negedge clk) begin
      if (!reset) begin
         en6_or = '0;
      end else begin
         en6_or |= lat_en6;
         if (ack6 != '0) begin
            if (q6.size() == 0) begin
               chk("u6_unexpected", ack6, 0);
            end else begin
               e6 = q6.pop_front();
               chk("u6_ack", ack6, e6.ack);
               chk("u6_err", err6, e6.err);
               chk("u6_lat_en", en6_or, e6.en);
            end
            en6_or = '0;
         end
      end
   end

   task automatic wait_acks(input int n, input int budget, input string nm);
      int got = 0;
      for (int i = 0; i < budget && got < n; i++) begin
         @(negedge clk);
         if (ack != '0) got++;
      end
      chk(nm, got, n);
   endtask

   task automatic drain(input int budget, input string nm);
      for (int i = 0; i < budget && q.size() > 0; i++) @(negedge clk);
      chk(nm, q.size(), 0);
      q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      int got6;
      int seen;
      repeat (3) @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      chk("rst_clr_done", clr_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_lat_en", lat_en, 0);
      chk("rst_lat_d", lat_d, 0);
      chk("rst_lat_rst_n", lat_rst_n, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("rel_lat_rst_n", lat_rst_n, 1);
      chk("rel_busy", busy, 0);

      // all four requesting continuously
      req_addr = {3'd7, 3'd5, 3'd3, 3'd1};
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      req = 4'b1111;
      q.push_back(mk(0, 4'b0001, 0, 8'h02, 8'h11, cyc_p + 1, 3, 0));
      q.push_back(mk(0, 4'b0010, 0, 8'h08, 8'h22, 0, -1, 4));
      q.push_back(mk(0, 4'b0100, 0, 8'h20, 8'h33, 0, -1, 4));
      q.push_back(mk(0, 4'b1000, 0, 8'h80, 8'h44, 0, -1, 4));
      q.push_back(mk(0, 4'b0001, 0, 8'h02, 8'h11, 0, -1, 4));
      wait_acks(5, 60, "rr_acks");
      req = '0;
      drain(20, "rr_drain");
      repeat (2) @(negedge clk);

      // single write from requester 2
      req_addr = {3'd0, 3'd5, 3'd0, 3'd0};
      req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
      req = 4'b0100;
      q.push_back(mk(0, 4'b0100, 0, 8'h20, 8'hA5, cyc_p + 1, 3, 0));
      wait_acks(1, 20, "single_ack");
      req = '0;
      drain(20, "single_drain");
      repeat (2) @(negedge clk);

      // clear wins over a simultaneous request
      req_addr = {3'd0, 3'd0, 3'd0, 3'd4};
      req_data = {8'h00, 8'h00, 8'h00, 8'h5A};
      req = 4'b0001;
      clr = 1'b1;
      q.push_back(mk(1, 4'b0000, 0, 8'h00, 8'h00, cyc_p + 1, 2, 0));
      q.push_back(mk(0, 4'b0001, 0, 8'h10, 8'h5A, 0, -1, 4));
      @(negedge clk);
      clr = 1'b0;
      wait_acks(1, 30, "clr_then_req_ack");
      req = '0;
      drain(20, "clr_drain");

      // out-of-range address on the 6-latch instance
      addr6 = {3'd0, 3'd0, 3'd7, 3'd0};
      data6 = {8'h00, 8'h00, 8'h77, 8'h00};
      req6 = 4'b0010;
      q6.push_back(mk(0, 4'b0010, 1, 8'h00, 8'h77, 0, -1, 0));
      got6 = 0;
      for (int i = 0; i < 20 && got6 == 0; i++) begin
         @(negedge clk);
         if (ack6 != '0) got6 = 1;
      end
      req6 = '0;
      chk("u6_ack_seen", got6, 1);
      @(negedge clk);
      chk("u6_drain", q6.size(), 0);
      repeat (2) @(negedge clk);

      // reset while the enable is visible aborts the write
      req_addr = {3'd2, 3'd0, 3'd0, 3'd0};
      req_data = {8'hC3, 8'h00, 8'h00, 8'h00};
      req = 4'b1000;
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         @(negedge clk);
         if (lat_en != '0) seen = 1;
      end
      chk("abort_en_seen", seen, 1);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_lat_en", lat_en, 0);
      chk("abort_lat_rst_n", lat_rst_n, 0);
      chk("abort_ack", ack, 0);
      req = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_no_late_ack", ack, 0);

      // pointer back at 0: requester 0 beats requester 3
      req_addr = {3'd2, 3'd0, 3'd0, 3'd6};
      req_data = {8'hC3, 8'h00, 8'h00, 8'h0F};
      req = 4'b1001;
      q.push_back(mk(0, 4'b0001, 0, 8'h40, 8'h0F, cyc_p + 1, 3, 0));
      wait_acks(1, 20, "ptr_reset_ack");
      req = '0;
      drain(20, "ptr_reset_drain");
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/latch_bank_ctrl.md
Name: latch_bank_ctrl

Overview:
- Write sequencer and round-robin arbiter for a bank of NLAT level-sensitive D latches (d/enable/active-low reset cells) shared by NREQ requesters.
- Serialises writes and drives one common data bus plus one-hot latch enables with guaranteed setup/enable/hold phases, so data never changes while any enable is high.
- Also issues a bank-wide clear on the latches' active-low reset.

Parameters:
NREQ, 4, number of requesters (≥2)
NLAT, 8, number of latches in the bank (≥2)
DW, 8, latch data width
SETUP_CYC, 1, cycles lat_d is stable before enable (≥1)
EN_CYC, 1, cycles lat_en is high (≥1)
HOLD_CYC, 1, cycles lat_d is held after enable falls (≥1)
(derived) AW = clog2(NLAT)

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-low reset
req  in  NREQ  per-requester write request, level, held until ack
req_addr  in  NREQ*AW  packed target latch index per requester
req_data  in  NREQ*DW  packed write data per requester
clr  in  1  bank clear request, level
ack  out  NREQ  one-cycle completion pulse to the winning requester
err  out  1  pulses with ack when the captured address ≥ NLAT
clr_done  out  1  one-cycle pulse when a clear completes
busy  out  1  high whenever the FSM is not IDLE
lat_d  out  DW  shared latch data bus
lat_en  out  NLAT  one-hot latch enables
lat_rst_n  out  1  active-low reset to all latches

Behaviour:
- While reset=0: state IDLE, rr pointer 0, lat_en=0, lat_d=0, ack=0, err=0, clr_done=0, busy=0, lat_rst_n=0 (bank is cleared during reset).
- lat_rst_n rises on the first clock edge after reset is released.
- All outputs are registered.
- IDLE:
  - clr=1 takes priority over req → CLEAR.
  - Otherwise, with any req high, the arbiter picks the first asserted req at or after the pointer (wrapping modulo NREQ). Winner index, addr and data are captured → SETUP.
  - Nothing pending → stay IDLE, with lat_d holding its last value.
- SETUP: lat_d = captured data, lat_en=0, SETUP_CYC cycles → ENABLE.
- ENABLE: lat_en[addr]=1 (all zeros if addr ≥ NLAT), lat_d stable, EN_CYC cycles → HOLD.
- HOLD: lat_en=0, lat_d stable, HOLD_CYC cycles. On the final HOLD cycle, ack[winner]=1 (and err=1 if addr ≥ NLAT), pointer ← (winner+1) mod NREQ → IDLE.
- CLEAR: lat_rst_n=0 and lat_en=0 for exactly 1 cycle, then clr_done=1 for 1 cycle → IDLE. A clr still high in IDLE starts another clear.
- Latency: ack is asserted SETUP_CYC+EN_CYC+HOLD_CYC cycles after the capture edge. With defaults, req high at edge N gives ack high during cycle N+3.
- No back-to-back overlap: at least one IDLE cycle separates operations, and lat_en is never high in IDLE, SETUP, HOLD or CLEAR.
- Requester protocol: hold req/addr/data stable until ack; deassert in the ack cycle if no further write is wanted.
  - Inputs are sampled only at capture; changes afterwards are ignored.
  - A req dropped mid-operation still completes and still receives ack.
- A single phase counter of width clog2(max(SETUP_CYC,EN_CYC,HOLD_CYC)+1) is reloaded on every phase entry.
- reset=0 mid-operation aborts on the next edge: lat_en drops to 0 and no ack is issued.

Optional Feature:
LATCH_SHADOW_EN
- Defined: adds input rd_addr (AW) and output rd_data (DW). A shadow register array is written in the last ENABLE cycle with the captured data, and zeroed on CLEAR and reset. rd_data is a registered read, 1-cycle latency, 0 for out-of-range addresses.
- Undefined: these ports and the array are absent; all other behaviour is identical.

Decomposition:
- Package latch_ctrl_pkg:
  - FSM state enum (IDLE, SETUP, ENABLE, HOLD, CLEAR)
  - AW derivation function
  - phase-counter width function
- One sub-module, rr_arbiter (NREQ):
  - req vector + pointer in, one-hot grant + index out, combinational.
  - The controller owns the pointer register.

Test Plan:
- Reset held 3 cycles, then released → all outputs 0 during reset; lat_rst_n=1 on the first edge after release.
- req[2]=1, addr=5, data=8'hA5, defaults → lat_d=A5 from capture+1; lat_en=8'b0010_0000 for exactly 1 cycle; ack[2] at capture+3; err=0.
- req=4'b1111 held continuously → grants and acks in order 0,1,2,3,0; each write separated by one IDLE cycle; lat_en never high in two consecutive operations without a gap.
- clr and req[0] asserted together in IDLE → CLEAR first (lat_rst_n=0 for 1 cycle, clr_done pulse); req[0] served afterwards.
- req[1] with addr ≥ NLAT (NLAT=6, addr=7) → lat_en stays 0 throughout; ack[1] and err both pulse.
- reset driven low during ENABLE → lat_en=0 and lat_rst_n=0 on the next edge; no ack; after release the pointer restarts at 0.
